// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file.
// Clear-sequencer state encoding and address-width helper.
package rf_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  function automatic int rf_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Self-clearing reset sequencer: after reset, walks every address writing
// zero, then releases the file by dropping busy.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int AW    = rf_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);

  rf_state_t   state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;

  // State and clear-counter registers; reset restarts the sweep from address 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and clear write strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      RF_CLEAR: begin
        clr_we = ~reset;
        cnt_d  = cnt_q + (AW+1)'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = RF_RUN;
        end else begin
          state_d = RF_CLEAR;
        end
      end
      RF_RUN: begin
        state_d = RF_RUN;
      end
      default: begin
        state_d = RF_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset itself also counts as busy so nothing leaks out during the reset cycle.
  assign busy     = (state_q == RF_CLEAR) | reset;
  assign clr_addr = cnt_q[AW-1:0];

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with one synchronous write port, optional
// hardwired-zero register 0, optional write-to-read bypass and self-clear.
module regfile_mp
  import rf_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  parameter  int NR       = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = rf_aw(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [WIDTH-1:0]    wd,
  input  logic [NR*AW-1:0]    ra,
  output logic [NR*WIDTH-1:0] rd,
  output logic                busy
);

  logic [WIDTH-1:0] rf_q [DEPTH];

  logic             busy_s;
  logic             clr_we_s;
  logic [AW-1:0]    clr_addr_s;
  logic             wr_en_s;
  logic [AW-1:0]    wr_addr_s;
  logic [WIDTH-1:0] wr_data_s;

  rf_clear_seq #(
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .busy     (busy_s),
    .clr_we   (clr_we_s),
    .clr_addr (clr_addr_s)
  );

  // Single array write port shared by the clear sweep and the user write.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = clr_addr_s;
    wr_data_s = '0;
    if (clr_we_s) begin
      wr_en_s = 1'b1;
    end else if (!busy_s && we && !((ZERO_REG != 0) && (wa == '0))) begin
      wr_en_s   = 1'b1;
      wr_addr_s = wa;
      wr_data_s = wd;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Storage array; contents are only meaningful once the first clear completes.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      rf_q[wr_addr_s] <= wr_data_s;
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0]    ra_s;
    logic [WIDTH-1:0] rd_s;

    assign ra_s = ra[i*AW +: AW];

    // Per-port read: zero register beats bypass, bypass beats array contents.
    always_comb begin
      rd_s = '0;
      if (busy_s) begin
        rd_s = '0;
      end else if ((ZERO_REG != 0) && (ra_s == '0)) begin
        rd_s = '0;
      end else if ((BYPASS != 0) && we && (wa == ra_s)) begin
        rd_s = wd;
      end else begin
        rd_s = rf_q[ra_s];
      end
    end

    assign rd[i*WIDTH +: WIDTH] = rd_s;
  end

  assign busy = busy_s;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two configurations driven by the same stimulus,
// checked each cycle against an array model plus directed literal checks.
module tb_regfile_mp;

  localparam int W = 32;
  localparam int D = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          we = 1'b0;
  logic [4:0]    wa = 5'd0;
  logic [31:0]   wd = 32'd0;
  logic [14:0]   ra_a = 15'd0;
  logic [9:0]    ra_b;
  logic [95:0]   rd_a;
  logic [63:0]   rd_b;
  logic          busy_a, busy_b;

  int n_checks = 0;
  int n_errors = 0;

  // Model: edges since reset released, and the architectural contents.
  int          rel_cnt = 0;
  logic [31:0] mem_a [D];
  logic [31:0] mem_b [D];

  assign ra_b = ra_a[9:0];

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NR(3), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
    .ra(ra_a), .rd(rd_a), .busy(busy_a)
  );

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NR(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
    .ra(ra_b), .rd(rd_b), .busy(busy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic busy_exp();
    return reset || (rel_cnt < D);
  endfunction

  function automatic logic [31:0] exp_a(input int p);
    logic [4:0] a;
    a = ra_a[p*5 +: 5];
    if (busy_exp()) return 32'd0;
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return mem_a[a];
  endfunction

  function automatic logic [31:0] exp_b(input int p);
    logic [4:0] a;
    a = ra_b[p*5 +: 5];
    if (busy_exp()) return 32'd0;
    return mem_b[a];
  endfunction

  // Model update: a completed sweep zeroes the file; writes only land when idle.
  always @(posedge clk) begin
    if (reset) begin
      rel_cnt <= 0;
    end else if (rel_cnt < D) begin
      rel_cnt <= rel_cnt + 1;
      if (rel_cnt == D - 1) begin
        for (int k = 0; k < D; k++) begin
          mem_a[k] <= 32'd0;
          mem_b[k] <= 32'd0;
        end
      end
    end else if (we) begin
      if (wa != 5'd0) mem_a[wa] <= wd;
      mem_b[wa] <= wd;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("cmp_busy_a", {31'd0, busy_a}, {31'd0, busy_exp()});
    chk("cmp_busy_b", {31'd0, busy_b}, {31'd0, busy_exp()});
    for (int p = 0; p < 3; p++)
      chk($sformatf("cmp_a_rd%0d", p), rd_a[p*32 +: 32], exp_a(p));
    for (int p = 0; p < 2; p++)
      chk($sformatf("cmp_b_rd%0d", p), rd_b[p*32 +: 32], exp_b(p));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until busy drops after reset release; expects DEPTH.
  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy_a && n < 100) begin
      step();
      n++;
    end
    chk(name, n, 32'd32);
  endtask

  initial begin
    // 1: reset, 32-edge clear, all registers zero on every port
    step();
    step();
    reset = 1'b0;
    #1;
    chk("busy_after_release", {31'd0, busy_a}, 32'd1);
    count_busy("clear_edges");
    chk("busy_b_done", {31'd0, busy_b}, 32'd0);
    for (int r = 0; r < D; r++) begin
      ra_a = {5'(r), 5'(r), 5'(31 - r)};
      #1;
      chk("zero_a_rd1", rd_a[63:32], 32'd0);
      chk("zero_b_rd0", rd_b[31:0], 32'd0);
      step();
    end

    // 2: writes to x0 are dropped only when ZERO_REG=1
    we = 1'b1; wa = 5'd0; wd = 32'hDEADBEEF; ra_a = 15'd0;
    #1;
    chk("x0_a_wcycle", rd_a[31:0], 32'd0);
    chk("x0_b_wcycle", rd_b[31:0], 32'd0);
    step();
    we = 1'b0;
    #1;
    chk("x0_a_after", rd_a[31:0], 32'd0);
    chk("x0_b_after", rd_b[31:0], 32'hDEADBEEF);

    // 3: bypass on instance a, old value on instance b
    we = 1'b1; wa = 5'd5; wd = 32'h12345678; ra_a = {5'd0, 5'd0, 5'd5};
    #1;
    chk("byp_a_wcycle", rd_a[31:0], 32'h12345678);
    chk("nobyp_b_wcycle", rd_b[31:0], 32'd0);
    step();
    we = 1'b0;
    #1;
    chk("byp_a_next", rd_a[31:0], 32'h12345678);
    chk("nobyp_b_next", rd_b[31:0], 32'h12345678);

    // 4: several ports reading the same address
    we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; ra_a = 15'd0;
    step();
    we = 1'b0; ra_a = {5'd7, 5'd7, 5'd7};
    #1;
    for (int p = 0; p < 3; p++)
      chk($sformatf("same_a_rd%0d", p), rd_a[p*32 +: 32], 32'hA5A5A5A5);
    chk("same_b_rd1", rd_b[63:32], 32'hA5A5A5A5);

    // 5+6: reset mid-clear restarts; writes while busy never land
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) step();
    reset = 1'b1;
    we = 1'b1; wa = 5'd3; wd = 32'h00000055;
    step();
    chk("busy_midreset", {31'd0, busy_a}, 32'd1);
    reset = 1'b0;
    count_busy("restart_edges");
    we = 1'b0; ra_a = {5'd7, 5'd5, 5'd3};
    #1;
    chk("busy_write_a", rd_a[31:0], 32'd0);
    chk("busy_write_b", rd_b[31:0], 32'd0);
    chk("cleared_x5_b", rd_b[63:32], 32'd0);
    step();

    // Random traffic, narrow address range to exercise bypass and collisions
    for (int c = 0; c < 10000; c++) begin
      reset = ($urandom_range(0, 1999) == 0);
      we    = 1'($urandom_range(0, 1));
      wa    = 5'($urandom_range(0, 7));
      wd    = $urandom;
      ra_a  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      step();
    end
    reset = 1'b0;
    we = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
